// File: rtl/w0rm_timer_pkg.sv
// Shared constants and register-file layout for the W0RM interval timer peripheral.
package w0rm_timer_pkg;

  localparam int unsigned RegWidth      = 32;
  localparam int unsigned PrescaleWidth = 16;
  localparam int unsigned CtrlWidth     = 3;

  // Word offsets within the 32-byte window.
  localparam logic [2:0] RegCtrl     = 3'd0;
  localparam logic [2:0] RegStatus   = 3'd1;
  localparam logic [2:0] RegLimit    = 3'd2;
  localparam logic [2:0] RegCount    = 3'd3;
  localparam logic [2:0] RegPrescale = 3'd4;

  localparam int unsigned CtrlEnable     = 0;
  localparam int unsigned CtrlAutoReload = 1;
  localparam int unsigned CtrlIrqEn      = 2;

  typedef struct packed {
    logic [CtrlWidth-1:0]     ctrl;
    logic                     expired;
    logic [RegWidth-1:0]      limit;
    logic [RegWidth-1:0]      count;
    logic [PrescaleWidth-1:0] prescale;
  } timer_regs_t;

endpackage

// File: rtl/w0rm_timer_prescaler.sv
// Prescaler: counts 0..limit while enabled and flags a tick on the terminal count.
module w0rm_timer_prescaler
  import w0rm_timer_pkg::*;
(
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     enable_i,
  input  logic                     restart_i,
  input  logic [PrescaleWidth-1:0] limit_i,
  output logic                     tick_o
);

  logic [PrescaleWidth-1:0] cnt_q, cnt_d;

  assign tick_o = enable_i & (cnt_q == limit_i);

  always_comb begin
    cnt_d = cnt_q + PrescaleWidth'(1);
    if (!enable_i || restart_i || tick_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/w0rm_peripheral_timer.sv
// Memory-mapped interval timer on the W0RM data bus: decode, register file, counter and
// single-cycle registered response.
module w0rm_peripheral_timer
  import w0rm_timer_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h800000A0
) (
  input  logic                  mem_clk,
  input  logic                  cpu_reset,
  input  logic                  mem_valid_i,
  input  logic                  mem_read_i,
  input  logic                  mem_write_i,
  input  logic [ADDR_WIDTH-1:0] mem_addr_i,
  input  logic [DATA_WIDTH-1:0] mem_data_i,
  output logic                  mem_valid_o,
  output logic [DATA_WIDTH-1:0] mem_data_o,
  output logic                  timer_irq_o,
  output logic                  timer_tick_o
);

  timer_regs_t           regs_q, regs_d;
  logic                  rsp_valid_q;
  logic [DATA_WIDTH-1:0] rsp_data_q, rdata;
  logic                  tick_q, tick_d;

  logic       hit, wr_en, rd_en, restart, presc_tick, tick_eff;
  logic [2:0] offset;
  logic       unused_addr;

  assign hit    = mem_valid_i & (mem_read_i | mem_write_i) &
                  (mem_addr_i[ADDR_WIDTH-1:5] == BASE_ADDR[ADDR_WIDTH-1:5]);
  assign wr_en  = hit & mem_write_i;
  assign rd_en  = hit & ~mem_write_i;
  assign offset = mem_addr_i[4:2];
  assign unused_addr = ^mem_addr_i[1:0];

  assign restart  = wr_en & (offset == RegCtrl) & mem_data_i[CtrlEnable];
  // A bus write to COUNT swallows a coincident tick entirely (no increment, no expiry).
  assign tick_eff = presc_tick & ~(wr_en & (offset == RegCount));

  w0rm_timer_prescaler u_prescaler (
    .clk_i     (mem_clk),
    .rst_i     (cpu_reset),
    .enable_i  (regs_q.ctrl[CtrlEnable]),
    .restart_i (restart),
    .limit_i   (regs_q.prescale),
    .tick_o    (presc_tick)
  );

  always_comb begin
    rdata = '0;
    if (rd_en) begin
      case (offset)
        RegCtrl:     rdata = DATA_WIDTH'(regs_q.ctrl);
        RegStatus:   rdata = DATA_WIDTH'(regs_q.expired);
        RegLimit:    rdata = regs_q.limit;
        RegCount:    rdata = regs_q.count;
        RegPrescale: rdata = DATA_WIDTH'(regs_q.prescale);
        default:     rdata = '0;
      endcase
    end
  end

  // Order matters: W1C before expiry (set wins), bus writes last (write wins).
  always_comb begin
    regs_d = regs_q;
    tick_d = 1'b0;
    if (wr_en && (offset == RegStatus) && mem_data_i[0]) begin
      regs_d.expired = 1'b0;
    end
    if (tick_eff) begin
      if (regs_q.count == regs_q.limit) begin
        regs_d.expired = 1'b1;
        regs_d.count   = '0;
        tick_d         = 1'b1;
        if (!regs_q.ctrl[CtrlAutoReload]) begin
          regs_d.ctrl[CtrlEnable] = 1'b0;
        end
      end else begin
        regs_d.count = regs_q.count + RegWidth'(1);
      end
    end
    if (wr_en) begin
      case (offset)
        RegCtrl:     regs_d.ctrl     = mem_data_i[CtrlWidth-1:0];
        RegLimit:    regs_d.limit    = mem_data_i;
        RegCount:    regs_d.count    = mem_data_i;
        RegPrescale: regs_d.prescale = mem_data_i[PrescaleWidth-1:0];
        default:     ;
      endcase
    end
  end

  always_ff @(posedge mem_clk) begin
    if (cpu_reset) begin
      regs_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      tick_q      <= 1'b0;
    end else begin
      regs_q      <= regs_d;
      rsp_valid_q <= hit;
      rsp_data_q  <= rdata;
      tick_q      <= tick_d;
    end
  end

  assign mem_valid_o  = rsp_valid_q;
  assign mem_data_o   = rsp_data_q;
  assign timer_tick_o = tick_q;
  assign timer_irq_o  = regs_q.expired & regs_q.ctrl[CtrlIrqEn];

endmodule
